// File: rtl/ex_mem_reg_pkg.sv
// Shared core defines: enable levels, NOP encodings and bus widths used by the
// EX/MEM pipeline register.
package ex_mem_reg_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int ALU_OP_BUS_W   = 8;
  localparam int DOUBLE_REG_W   = 2 * REG_BUS_W;
  localparam int STALL_BUS_W    = 6;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;

  localparam logic [REG_BUS_W-1:0]      ZERO_WORD    = '0;
  localparam logic [REG_ADDR_BUS_W-1:0] NOP_REG_ADDR = '0;
  localparam logic [ALU_OP_BUS_W-1:0]   EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [ALU_OP_BUS_W-1:0]   EXE_SW_OP    = 8'b1110_1011;

  typedef logic [REG_BUS_W-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_bus_t;
  typedef logic [ALU_OP_BUS_W-1:0]   alu_op_bus_t;
  typedef logic [DOUBLE_REG_W-1:0]   double_reg_bus_t;

  // What the register does on the next edge, highest priority first.
  typedef enum logic [1:0] {
    CAP_FLUSH  = 2'd0,
    CAP_BUBBLE = 2'd1,
    CAP_HOLD   = 2'd2,
    CAP_PASS   = 2'd3
  } cap_mode_e;

  function automatic cap_mode_e cap_mode(input logic flush, input logic ex_stop,
                                         input logic mem_stop);
    if (flush)                                   return CAP_FLUSH;
    if (ex_stop == STOP && mem_stop == NO_STOP)  return CAP_BUBBLE;
    if (ex_stop == STOP)                         return CAP_HOLD;
    return CAP_PASS;
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures execute results, honours stall/flush, and
// carries the madd/msub partial product and cycle count back to execute.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int STALL_W    = 6,
  parameter int STAGE_IDX  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic [1:0]            cnt_i,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic [1:0]            cnt_o
);

  localparam logic [REG_ADDR_W-1:0] NOP_WD = REG_ADDR_W'(NOP_REG_ADDR);
  localparam logic [ALUOP_W-1:0]    NOP_OP = ALUOP_W'(EXE_NOP_OP);

  cap_mode_e mode;

  // The ex=run/mem=stop pattern is never issued; it falls through to pass.
  always_comb begin
    mode = cap_mode(flush, stall[STAGE_IDX], stall[STAGE_IDX+1]);
  end

  // Memory-stage payload: cleared on flush and bubble, frozen on hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      mem_wd       <= NOP_WD;
      mem_wreg     <= WRITE_DISABLE;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= WRITE_DISABLE;
      mem_aluop    <= NOP_OP;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
    end else begin
      unique case (mode)
        CAP_FLUSH, CAP_BUBBLE: begin
          mem_wd       <= NOP_WD;
          mem_wreg     <= WRITE_DISABLE;
          mem_wdata    <= '0;
          mem_hi       <= '0;
          mem_lo       <= '0;
          mem_whilo    <= WRITE_DISABLE;
          mem_aluop    <= NOP_OP;
          mem_mem_addr <= '0;
          mem_reg2     <= '0;
        end
        CAP_HOLD: ;
        CAP_PASS: begin
          mem_wd       <= ex_wd;
          mem_wreg     <= ex_wreg;
          mem_wdata    <= ex_wdata;
          mem_hi       <= ex_hi;
          mem_lo       <= ex_lo;
          mem_whilo    <= ex_whilo;
          mem_aluop    <= ex_aluop;
          mem_mem_addr <= ex_mem_addr;
          mem_reg2     <= ex_reg2;
        end
        default: ;
      endcase
    end
  end

  // madd/msub state survives a bubble so execute can finish across the stall;
  // a completed pass means no multi-cycle op is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      hilo_o <= '0;
      cnt_o  <= 2'd0;
    end else begin
      unique case (mode)
        CAP_FLUSH, CAP_PASS: begin
          hilo_o <= '0;
          cnt_o  <= 2'd0;
        end
        CAP_BUBBLE: begin
          hilo_o <= hilo_i;
          cnt_o  <= cnt_i;
        end
        CAP_HOLD: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: reset, table vectors, hand sequences and a
// randomized run against a rule-level reference model.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic        ex_whilo;
  logic [7:0]  ex_aluop;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi),
    .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_aluop(ex_aluop),
    .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  always @(posedge clk)
    if (!rst) assert (!(stall[3] == 1'b0 && stall[4] == 1'b1))
      else $error("illegal stall pattern %b", stall);

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata, hi, lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] addr, reg2;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } st_t;

  st_t act;
  assign act = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
                mem_mem_addr, mem_reg2, hilo_o, cnt_o};

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic chk_all(input string tag, input st_t e);
    chk({tag, ".wd"}, 64'(act.wd), 64'(e.wd));
    chk({tag, ".wreg"}, 64'(act.wreg), 64'(e.wreg));
    chk({tag, ".wdata"}, 64'(act.wdata), 64'(e.wdata));
    chk({tag, ".hi"}, 64'(act.hi), 64'(e.hi));
    chk({tag, ".lo"}, 64'(act.lo), 64'(e.lo));
    chk({tag, ".whilo"}, 64'(act.whilo), 64'(e.whilo));
    chk({tag, ".aluop"}, 64'(act.aluop), 64'(e.aluop));
    chk({tag, ".addr"}, 64'(act.addr), 64'(e.addr));
    chk({tag, ".reg2"}, 64'(act.reg2), 64'(e.reg2));
    chk({tag, ".hilo"}, act.hilo, e.hilo);
    chk({tag, ".cnt"}, 64'(act.cnt), 64'(e.cnt));
  endtask

  // Reference: what the memory stage should see after one edge with current inputs.
  function automatic st_t model(input st_t cur);
    st_t nxt;
    bit ex_stopped  = stall[3];
    bit mem_stopped = stall[4];
    nxt = cur;
    if (flush) nxt = '0;
    else if (ex_stopped && !mem_stopped) begin
      nxt = '0;
      nxt.hilo = hilo_i;
      nxt.cnt  = cnt_i;
    end else if (!ex_stopped) begin
      nxt = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, hi: ex_hi, lo: ex_lo,
              whilo: ex_whilo, aluop: ex_aluop, addr: ex_mem_addr, reg2: ex_reg2,
              hilo: 64'd0, cnt: 2'd0};
    end
    return nxt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[15];
  st_t  exp_st;

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0;
    ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_hi = '0; ex_lo = '0;
    ex_whilo = 1'b0; ex_aluop = '0; ex_mem_addr = '0; ex_reg2 = '0;
    hilo_i = '0; cnt_i = '0;
    #1;
    chk_all("reset_init", '0);
    tick();
    rst = 1'b0;

    // Straight pass of the test-plan values.
    ex_wd = 5'd8; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678; ex_whilo = 1'b1;
    ex_hi = 32'hA; ex_lo = 32'hB; hilo_i = 64'h77; cnt_i = 2'd2;
    tick();
    chk_all("pass", '{wd: 5'd8, wreg: 1'b1, wdata: 32'h1234_5678, hi: 32'hA,
                      lo: 32'hB, whilo: 1'b1, aluop: 8'h0, addr: 32'h0,
                      reg2: 32'h0, hilo: 64'h0, cnt: 2'd0});

    // Store passthrough.
    ex_aluop = 8'b1110_1011; ex_mem_addr = 32'h0000_0100; ex_reg2 = 32'hCAFE_0001;
    ex_wreg = 1'b0; ex_whilo = 1'b0; ex_wd = 5'd0; ex_wdata = 32'h0; ex_hi = 0; ex_lo = 0;
    tick();
    chk_all("store", '{wd: 5'd0, wreg: 1'b0, wdata: 32'h0, hi: 32'h0, lo: 32'h0,
                       whilo: 1'b0, aluop: 8'hEB, addr: 32'h100,
                       reg2: 32'hCAFE_0001, hilo: 64'h0, cnt: 2'd0});

    // Async reset mid-cycle, held across an edge, released under a hold stall.
    #3 rst = 1'b1;
    #1 chk_all("reset_async", '0);
    ex_wd = 5'd31; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_FFFF;
    tick();
    chk_all("reset_held", '0);
    stall = 6'b011111;
    rst = 1'b0;
    tick();
    chk_all("reset_release_hold", '0);

    vecs[0]  = '{6'b000000, 0, 5'd8,  32'h1234_5678, 64'h5,           2'd2, 5'd8,  1, 32'h1234_5678, 64'h0,           2'd0};
    vecs[1]  = '{6'b001111, 0, 5'd9,  32'h1111,      64'h1_0000_0002, 2'd1, 5'd0,  0, 32'h0,         64'h1_0000_0002, 2'd1};
    vecs[2]  = '{6'b000000, 0, 5'd10, 32'h2222,      64'h7,           2'd2, 5'd10, 1, 32'h2222,      64'h0,           2'd0};
    vecs[3]  = '{6'b000000, 0, 5'd3,  32'hDEAD_BEEF, 64'h0,           2'd0, 5'd3,  1, 32'hDEAD_BEEF, 64'h0,           2'd0};
    vecs[4]  = '{6'b011111, 0, 5'd4,  32'h4444,      64'h9,           2'd1, 5'd3,  1, 32'hDEAD_BEEF, 64'h0,           2'd0};
    vecs[5]  = '{6'b011111, 0, 5'd5,  32'h5555,      64'hA,           2'd2, 5'd3,  1, 32'hDEAD_BEEF, 64'h0,           2'd0};
    vecs[6]  = '{6'b011111, 0, 5'd6,  32'h6666,      64'hB,           2'd1, 5'd3,  1, 32'hDEAD_BEEF, 64'h0,           2'd0};
    vecs[7]  = '{6'b001111, 0, 5'd7,  32'h7777,      64'hAB,          2'd2, 5'd0,  0, 32'h0,         64'hAB,          2'd2};
    vecs[8]  = '{6'b011111, 0, 5'd8,  32'h8888,      64'hCD,          2'd1, 5'd0,  0, 32'h0,         64'hAB,          2'd2};
    vecs[9]  = '{6'b001111, 0, 5'd9,  32'h9999,      64'hEF,          2'd0, 5'd0,  0, 32'h0,         64'hEF,          2'd0};
    vecs[10] = '{6'b000000, 0, 5'd11, 32'h3333,      64'h1,           2'd1, 5'd11, 1, 32'h3333,      64'h0,           2'd0};
    vecs[11] = '{6'b011111, 1, 5'd12, 32'hCCCC,      64'h2,           2'd2, 5'd0,  0, 32'h0,         64'h0,           2'd0};
    vecs[12] = '{6'b001111, 0, 5'd12, 32'hCCCC,      64'h12,          2'd1, 5'd0,  0, 32'h0,         64'h12,          2'd1};
    vecs[13] = '{6'b011111, 1, 5'd14, 32'hEEEE,      64'h3,           2'd2, 5'd0,  0, 32'h0,         64'h0,           2'd0};
    vecs[14] = '{6'b000000, 0, 5'd13, 32'h4444,      64'h4,           2'd1, 5'd13, 1, 32'h4444,      64'h0,           2'd0};

    ex_wreg = 1'b1;
    for (int i = 0; i < 15; i++) begin
      stall = vecs[i].stall; flush = vecs[i].flush; ex_wd = vecs[i].wd;
      ex_wdata = vecs[i].wdata; hilo_i = vecs[i].hilo; cnt_i = vecs[i].cnt;
      tick();
      chk($sformatf("vec%0d.wd", i), 64'(mem_wd), 64'(vecs[i].e_wd));
      chk($sformatf("vec%0d.wreg", i), 64'(mem_wreg), 64'(vecs[i].e_wreg));
      chk($sformatf("vec%0d.wdata", i), 64'(mem_wdata), 64'(vecs[i].e_wdata));
      chk($sformatf("vec%0d.hilo", i), hilo_o, vecs[i].e_hilo);
      chk($sformatf("vec%0d.cnt", i), 64'(cnt_o), 64'(vecs[i].e_cnt));
    end
    flush = 1'b0;

    // Randomized run: model starts from the last table row's result.
    exp_st = act;
    for (int c = 0; c < 400; c++) begin
      stall = 6'($urandom);
      if (!stall[3]) stall[4] = 1'b0;
      flush       = ($urandom_range(0, 15) == 0);
      ex_wd       = 5'($urandom);
      ex_wreg     = 1'($urandom);
      ex_wdata    = $urandom;
      ex_hi       = $urandom;
      ex_lo       = $urandom;
      ex_whilo    = 1'($urandom);
      ex_aluop    = 8'($urandom);
      ex_mem_addr = $urandom;
      ex_reg2     = $urandom;
      hilo_i      = {$urandom, $urandom};
      cnt_i       = 2'($urandom_range(0, 2));
      exp_st = model(exp_st);
      tick();
      chk_all($sformatf("rand%0d", c), exp_st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
